// File: rtl/result_ascii_serializer_pkg.sv
// Shared encodings and ASCII constants for the result serializer
// and the RX-side operand parser.
package result_ascii_serializer_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] DELIM_SPACE = 8'h20;

  localparam logic [3:0] DIGITS = 4'd8;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'h01,
    ST_LOAD      = 8'h02,
    ST_SKIP      = 8'h04,
    ST_SEND      = 8'h08,
    ST_WAIT      = 8'h10,
    ST_TERM      = 8'h20,
    ST_TERM_WAIT = 8'h40,
    ST_DONE      = 8'h80
  } ser_state_e;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] n
  );
    logic [7:0] w;
    w = {4'h0, n};
    if (n < 4'd10)
      return ASCII_ZERO + w;
    else
      return ASCII_A + (w - 8'd10);
  endfunction

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
// Shared with the RX side through the package function.
module hex_nibble_ascii
  import result_ascii_serializer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_ascii(nibble);

endmodule

// File: rtl/result_ascii_serializer.sv
// Streams a 32-bit ALU result to a UART TX as uppercase hex,
// MSB nibble first, followed by a terminator byte.
module result_ascii_serializer
  import result_ascii_serializer_pkg::*;
#(
  parameter logic [7:0] TERMINATOR     = 8'h20,
  parameter bit         SUPPRESS_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  ser_state_e  state;
  ser_state_e  state_nxt;

  logic [31:0] shreg;
  logic [3:0]  cnt;
  logic        txd_q;
  logic [7:0]  hold_q;
  logic [7:0]  digit_ascii;

  logic        tx_edge;
  logic        top_zero;
  logic        more;
  logic        load;
  logic        skip_shift;
  logic        digit_shift;

  hex_nibble_ascii u_hex (
    .nibble (shreg[31:28]),
    .ascii  (digit_ascii)
  );

  assign tx_edge  = tx_done & ~txd_q;
  assign top_zero = (shreg[31:28] == 4'h0);
  assign more     = (cnt > 4'd1);

  assign load        = (state == ST_IDLE) & start;
  assign skip_shift  = (state == ST_SKIP) & top_zero & more;
  assign digit_shift = (state == ST_WAIT) & tx_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == ST_IDLE:
        if (start)
          state_nxt = ST_LOAD;
      state == ST_LOAD:
        state_nxt = SUPPRESS_ZEROS ? ST_SKIP
                                   : ST_SEND;
      state == ST_SKIP:
        if (!skip_shift)
          state_nxt = ST_SEND;
      state == ST_SEND:
        state_nxt = ST_WAIT;
      state == ST_WAIT:
        if (tx_edge)
          state_nxt = (cnt == 4'd1) ? ST_TERM
                                    : ST_SEND;
      state == ST_TERM:
        state_nxt = ST_TERM_WAIT;
      state == ST_TERM_WAIT:
        if (tx_edge)
          state_nxt = ST_DONE;
      state == ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Byte held through WAIT: the shift only happens on the edge
  // that ends the wait, so tx_data cannot move early.
  always_comb begin
    tx_start = 1'b0;
    done     = 1'b0;
    busy     = (state != ST_IDLE);
    tx_data  = hold_q;
    unique case (1'b1)
      state == ST_SEND: begin
        tx_start = 1'b1;
        tx_data  = digit_ascii;
      end
      state == ST_WAIT:
        tx_data = digit_ascii;
      state == ST_TERM: begin
        tx_start = 1'b1;
        tx_data  = TERMINATOR;
      end
      state == ST_TERM_WAIT:
        tx_data = TERMINATOR;
      state == ST_DONE: begin
        done    = 1'b1;
        tx_data = TERMINATOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= 32'h0;
      cnt    <= 4'h0;
      txd_q  <= 1'b0;
      hold_q <= 8'h00;
    end else begin
      txd_q  <= tx_done;
      hold_q <= tx_data;
      if (load) begin
        shreg <= result;
        cnt   <= DIGITS;
      end else if (skip_shift || digit_shift) begin
        shreg <= {shreg[27:0], 4'h0};
        cnt   <= cnt - 4'd1;
      end
    end
  end

endmodule
